// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Load-use stall and taken-branch flush controller for the
//               five-stage pipeline. Optional performance counters are
//               compiled in with HAZARD_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [4:0]  ID_RSAddr,
    input  logic [4:0]  ID_RTAddr,
    input  logic        ID_UsesRT,
    input  logic        EX_Mem2RegSEL,
    input  logic        EX_RegWriteEN,
    input  logic [4:0]  EX_DstAddr,
    input  logic        EX_BranchTaken,
    output logic        PCWriteEN,
    output logic        IFIDWriteEN,
    output logic        IFIDFlush,
    output logic        IDEXBubble,
    output logic [1:0]  HazState,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] c_stall_init = 2'(STALL_CYCLES - 1);
    localparam logic [1:0] c_flush_init = 2'(FLUSH_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_cnt;
    logic [1:0] w_next_cnt;
    logic       w_load_use;

    assign w_load_use = EX_Mem2RegSEL & EX_RegWriteEN & (EX_DstAddr != 5'd0) &
                        ((EX_DstAddr == ID_RSAddr) |
                         (ID_UsesRT & (EX_DstAddr == ID_RTAddr)));

    assign HazState = r_state;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= ST_RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        PCWriteEN    = 1'b1;
        IFIDWriteEN  = 1'b1;
        IFIDFlush    = 1'b0;
        IDEXBubble   = 1'b0;

        if (RESET) begin
            PCWriteEN    = 1'b0;
            IFIDWriteEN  = 1'b0;
            IFIDFlush    = 1'b1;
            IDEXBubble   = 1'b1;
            w_next_state = ST_RUN;
            w_next_cnt   = 2'd0;
        end else begin
            case (r_state)
                ST_RUN, ST_STALL: begin
                    if (EX_BranchTaken) begin
                        // A taken branch wins over any pending or new stall.
                        IFIDFlush  = 1'b1;
                        IDEXBubble = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            w_next_state = ST_FLUSH;
                            w_next_cnt   = c_flush_init;
                        end else begin
                            w_next_state = ST_RUN;
                            w_next_cnt   = 2'd0;
                        end
                    end else if (r_state == ST_STALL) begin
                        PCWriteEN   = 1'b0;
                        IFIDWriteEN = 1'b0;
                        IDEXBubble  = 1'b1;
                        w_next_cnt  = r_cnt - 2'd1;
                        if (r_cnt == 2'd1) begin
                            w_next_state = ST_RUN;
                        end
                    end else if (w_load_use) begin
                        PCWriteEN   = 1'b0;
                        IFIDWriteEN = 1'b0;
                        IDEXBubble  = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            w_next_state = ST_STALL;
                            w_next_cnt   = c_stall_init;
                        end
                    end
                end
                ST_FLUSH: begin
                    // EX holds a bubble, so hazard inputs are meaningless here.
                    IFIDFlush  = 1'b1;
                    IDEXBubble = 1'b1;
                    w_next_cnt = r_cnt - 2'd1;
                    if (r_cnt == 2'd1) begin
                        w_next_state = ST_RUN;
                    end
                end
                default: begin
                    w_next_state = ST_RUN;
                    w_next_cnt   = 2'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_stall_evt;
    logic        w_flush_evt;

    assign w_stall_evt = ~RESET & ~PCWriteEN;
    assign w_flush_evt = ~RESET & EX_BranchTaken & (r_state != ST_FLUSH);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_flush_evt && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign StallCount = r_stall_cnt;
    assign FlushCount = r_flush_cnt;
`else
    assign StallCount = 32'd0;
    assign FlushCount = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and flush controller for the five-stage pipeline. It watches the instruction being decoded and the instruction held in the ID/EX register, and drives the write-enable and bubble/flush controls of the PC, the IF/ID register and the ID/EX register. It inserts load-use stall bubbles and flushes wrong-path instructions after a taken branch using a small registered state machine. Optional performance counters are compiled in by macro.

## Interface
Parameters:
- STALL_CYCLES, 1, bubbles inserted per load-use hazard (legal 1..3).
- FLUSH_CYCLES, 2, cycles of IF/ID and ID/EX flush per taken branch (legal 1..3).

Ports:
- CLOCK  in  1  pipeline clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- ID_RSAddr  in  5  rs field of the instruction in ID.
- ID_RTAddr  in  5  rt field of the instruction in ID.
- ID_UsesRT  in  1  instruction in ID reads rt as a source.
- EX_Mem2RegSEL  in  1  instruction in EX is a load (Mem2RegSEL from ID/EX).
- EX_RegWriteEN  in  1  instruction in EX writes a register.
- EX_DstAddr  in  5  destination register of the instruction in EX (after RegDst mux).
- EX_BranchTaken  in  1  branch in EX resolved taken this cycle.
- PCWriteEN  out  1  PC may update.
- IFIDWriteEN  out  1  IF/ID register may load.
- IFIDFlush  out  1  IF/ID loads a NOP.
- IDEXBubble  out  1  ID/EX loads all control signals as 0.
- HazState  out  2  current state: 0 RUN, 1 STALL, 2 FLUSH.
- StallCount  out  32  cycles with PCWriteEN low.
- FlushCount  out  32  taken-branch flush events.

## Operation
- Load-use hazard LU = EX_Mem2RegSEL & EX_RegWriteEN & (EX_DstAddr != 0) & ((EX_DstAddr == ID_RSAddr) | (ID_UsesRT & EX_DstAddr == ID_RTAddr)).
- Outputs are combinational from the registered state and the current inputs (Mealy). State and 2-bit down-counter CNT are registered.
- RUN:
  - If EX_BranchTaken: PCWriteEN=1, IFIDWriteEN=1, IFIDFlush=1, IDEXBubble=1. If FLUSH_CYCLES>1, go to FLUSH with CNT=FLUSH_CYCLES-1; otherwise stay in RUN. A branch has priority over LU in the same cycle.
  - Else if LU: PCWriteEN=0, IFIDWriteEN=0, IFIDFlush=0, IDEXBubble=1. If STALL_CYCLES>1, go to STALL with CNT=STALL_CYCLES-1; otherwise stay in RUN.
  - Else: PCWriteEN=1, IFIDWriteEN=1, IFIDFlush=0, IDEXBubble=0.
- STALL: same outputs as the RUN+LU case. CNT decrements; when CNT==1, go to RUN. EX_BranchTaken here behaves as in RUN (flush, enter FLUSH or RUN) and aborts the stall.
- FLUSH: PCWriteEN=1, IFIDWriteEN=1, IFIDFlush=1, IDEXBubble=1. CNT decrements; when CNT==1, go to RUN. LU and EX_BranchTaken are ignored, because EX holds a bubble.
- While RESET is high: PCWriteEN=0, IFIDWriteEN=0, IFIDFlush=1, IDEXBubble=1. Next state is RUN with CNT=0 and counters=0. Reset mid-STALL or mid-FLUSH returns to RUN in the next cycle.

## Timing
- Hazard response has zero latency: controls assert in the same cycle LU or EX_BranchTaken is seen.
- One load-use hazard removes exactly STALL_CYCLES PC updates.
- One taken branch asserts IFIDFlush for exactly FLUSH_CYCLES consecutive cycles, starting in the resolve cycle.
- HazState shows the registered state; it changes one cycle after the triggering event.
- Counters update on the clock edge that closes the counted cycle. They saturate at 32'hFFFFFFFF and do not wrap.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - StallCount increments each non-reset cycle with PCWriteEN==0.
  - FlushCount increments once per taken branch accepted in RUN or STALL.
- Not defined: both counter ports are driven constant 0, no counter flops exist, and all other behaviour is identical.

## Test plan
- Reset with RESET high for 2 cycles, all inputs 0 -> PCWriteEN=0, IDEXBubble=1, IFIDFlush=1 during reset. After release: HazState=0, PCWriteEN=1, StallCount=0.
- STALL_CYCLES=1, EX_Mem2RegSEL=1, EX_RegWriteEN=1, EX_DstAddr=5, ID_RSAddr=5 for one cycle -> one cycle of PCWriteEN=0/IDEXBubble=1, then RUN. With the macro, StallCount=1.
- STALL_CYCLES=2, same load with ID_RTAddr=5, ID_UsesRT=1 -> PCWriteEN low 2 cycles, HazState=1 on the second. Repeat with EX_DstAddr=0 -> no stall.
- FLUSH_CYCLES=2, EX_BranchTaken=1 together with an LU condition -> IFIDFlush=1 for 2 cycles, PCWriteEN stays 1, FlushCount=1, StallCount unchanged.
- RESET asserted in the 2nd FLUSH cycle of FLUSH_CYCLES=3 -> HazState=0 in the next cycle, no further flush cycles, counters 0.
- Force StallCount to 32'hFFFFFFFE, then 3 stall cycles -> StallCount holds at 32'hFFFFFFFF.
